cfa_final_add: RTL and testbench

Pipelined carry-propagate adder that turns the two 16-bit carry-save vectors from the 8x8 Dadda reduction tree into the final binary product. It sits directly downstream of the multiplier tree and upstream of any consumer of the product. It uses a two-stage split-carry pipeline with a valid/ready handshake on both sides. Throughput is one product per cycle; backpressure stalls the pipeline without losing data.

---
 rtl/cfa_final_add_if.sv | 36 +++
 rtl/cfa_final_add.sv | 89 ++++++++
 tb/tb_cfa_final_add.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cfa_final_add_if.sv
// Handshake bundle for the final carry-propagate adder:
// carry-save pair in, binary product out.
interface cfa_final_add_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] vec_a;
  logic [WIDTH-1:0] vec_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             cout_err;

  modport master (
    output in_valid,
    output vec_a,
    output vec_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  cout_err
  );

  modport slave (
    input  in_valid,
    input  vec_a,
    input  vec_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output cout_err
  );
endinterface

// File: rtl/cfa_final_add.sv
// Two-stage split-carry adder folding the Dadda tree's
// carry-save vectors into the final product.
module cfa_final_add #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8
) (
  input logic           clk,
  input logic           rst_n,
  cfa_final_add_if.slave io
);
  localparam int HI = WIDTH - SPLIT;

  logic             s1_v;
  logic             s2_v;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_c;
  logic [HI-1:0]    s1_ahi;
  logic [HI-1:0]    s1_bhi;
  logic [WIDTH-1:0] prod_q;
  logic             cout_q;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic [SPLIT:0]   lo_sum;
  logic [HI:0]      hi_sum;

  // in_ready depends only on state and out_ready
  assign s2_free = !s2_v || io.out_ready;
  assign s1_adv  = s1_v && s2_free;
  assign accept  = io.in_valid && io.in_ready;

  assign io.in_ready  = !s1_v || s2_free;
  assign io.out_valid = s2_v;
  assign io.product   = prod_q;
  assign io.cout_err  = cout_q;

  assign lo_sum = {1'b0, io.vec_a[SPLIT-1:0]}
                + {1'b0, io.vec_b[SPLIT-1:0]};

  assign hi_sum = {1'b0, s1_ahi}
                + {1'b0, s1_bhi}
                + {{HI{1'b0}}, s1_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
    end else if (accept) begin
      s1_v <= 1'b1;
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo  <= '0;
      s1_c   <= 1'b0;
      s1_ahi <= '0;
      s1_bhi <= '0;
    end else if (accept) begin
      s1_lo  <= lo_sum[SPLIT-1:0];
      s1_c   <= lo_sum[SPLIT];
      s1_ahi <= io.vec_a[WIDTH-1:SPLIT];
      s1_bhi <= io.vec_b[WIDTH-1:SPLIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
    end else if (s1_adv) begin
      s2_v <= 1'b1;
    end else if (io.out_ready) begin
      s2_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      cout_q <= 1'b0;
    end else if (s1_adv) begin
      prod_q <= {hi_sum[HI-1:0], s1_lo};
      cout_q <= hi_sum[HI];
    end
  end

endmodule

// File: tb/tb_cfa_final_add.sv
// Directed and scoreboard bench for cfa_final_add:
// vector table, backpressure, streaming and mid-flight reset.
module tb_cfa_final_add;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cfa_final_add_if #(.WIDTH(16)) bus ();

  cfa_final_add #(
    .WIDTH(16),
    .SPLIT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic        c;
  } vec_t;

  vec_t vt [8];
  logic [16:0] sb [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one handshake cycle with scoreboard tracking
  task automatic cyc(input logic iv,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic ordy);
    logic acc;
    logic cons;
    logic [16:0] exp;
    bus.in_valid  = iv;
    bus.vec_a     = a;
    bus.vec_b     = b;
    bus.out_ready = ordy;
    #1;
    acc  = bus.in_valid && bus.in_ready;
    cons = bus.out_valid && bus.out_ready;
    if (cons) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(bus.product), 32'hxxxx);
      end else begin
        exp = sb.pop_front();
        chk("stream", 32'({bus.cout_err, bus.product}), 32'(exp));
      end
    end
    if (acc) sb.push_back({1'b0, a} + {1'b0, b});
    step();
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] r;
    n_cmp = 0;
    n_err = 0;
    vt[0] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
    vt[1] = '{16'h7F01, 16'h7F00, 16'hFE01, 1'b0};
    vt[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    vt[3] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vt[4] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
    vt[5] = '{16'h00FF, 16'h00FF, 16'h01FE, 1'b0};
    vt[6] = '{16'h0F0F, 16'hF0F1, 16'h0000, 1'b1};
    vt[7] = '{16'h0080, 16'h7F80, 16'h8000, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.vec_a     = '0;
    bus.vec_b     = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_product", 32'(bus.product), 32'h0);
    chk("rst_cout", 32'(bus.cout_err), 32'd0);
    step();

    // single transfers: visible exactly two edges after accept
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.vec_a     = vt[i].a;
      bus.vec_b     = vt[i].b;
      #1;
      chk("vec_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk("vec_lat1", 32'(bus.out_valid), 32'd0);
      step();
      chk("vec_lat2", 32'(bus.out_valid), 32'd1);
      chk("vec_product", 32'(bus.product), 32'(vt[i].p));
      chk("vec_cout", 32'(bus.cout_err), 32'(vt[i].c));
      step();
      chk("vec_drained", 32'(bus.out_valid), 32'd0);
    end

    // backpressure: two accepts fill the pipe
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.vec_a     = 16'd1;
    bus.vec_b     = 16'd1;
    step();
    bus.vec_a = 16'd2;
    bus.vec_b = 16'd2;
    #1;
    chk("bp_ready2", 32'(bus.in_ready), 32'd1);
    step();
    bus.vec_a = 16'd3;
    bus.vec_b = 16'd3;
    #1;
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_prod", 32'(bus.product), 32'h0002);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_recover_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_out2", 32'(bus.product), 32'h0004);
    chk("bp_out2_v", 32'(bus.out_valid), 32'd1);
    step();
    chk("bp_out3", 32'(bus.product), 32'h0006);
    chk("bp_out3_v", 32'(bus.out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // random streaming against the scoreboard
    for (int k = 0; k < 1000; k++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom),
          16'($urandom), 1'($urandom_range(0, 1)));
    end

    // every 8x8 product as a split carry-save pair
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        p = 16'(x * y);
        r = 16'($urandom_range(0, int'(p)));
        cyc(1'b1, p - r, r, 1'b1);
      end
    end

    for (int k = 0; k < 10; k++) begin
      if (sb.size() != 0) cyc(1'b0, '0, '0, 1'b1);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // mid-flight reset with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.vec_a     = 16'h1111;
    bus.vec_b     = 16'h2222;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("mf_full", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mf_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mf_rst_prod", 32'(bus.product), 32'h0);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mf_no_stale", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b1;
    bus.vec_a    = 16'h0005;
    bus.vec_b    = 16'h0006;
    step();
    bus.in_valid = 1'b0;
    chk("mf_lat1", 32'(bus.out_valid), 32'd0);
    step();
    chk("mf_lat2", 32'(bus.out_valid), 32'd1);
    chk("mf_prod", 32'(bus.product), 32'h000B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
